// File: rtl/polara_noc_pkg.sv
// Shared header field layout, FSM encoding and NoC message types for the Polara RX checker.
package polara_noc_pkg;

  localparam int CHIPID_LSB = 50;
  localparam int CHIPID_W   = 14;
  localparam int X_LSB      = 42;
  localparam int X_W        = 8;
  localparam int Y_LSB      = 34;
  localparam int Y_W        = 8;
  localparam int FBITS_LSB  = 30;
  localparam int FBITS_W    = 4;
  localparam int LEN_LSB    = 22;
  localparam int LEN_W      = 8;
  localparam int MSG_LSB    = 14;
  localparam int MSG_W      = 8;
  localparam int MSHR_LSB   = 6;
  localparam int MSHR_W     = 8;

  typedef enum logic {
    S_HDR     = 1'b0,
    S_PAYLOAD = 1'b1
  } rx_state_e;

  // Mirrored from define.tmp.h
  localparam logic [7:0] MSG_TYPE_LOAD_FWD  = 8'd16;
  localparam logic [7:0] MSG_TYPE_STORE_FWD = 8'd17;
  localparam logic [7:0] MSG_TYPE_INV_FWD   = 8'd18;
  localparam logic [7:0] MSG_TYPE_LOAD_MEM  = 8'd19;
  localparam logic [7:0] MSG_TYPE_STORE_MEM = 8'd20;

endpackage

// File: rtl/polara_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear has priority over increment.
module polara_sat_counter #(
  parameter int W = 32
) (
  input  logic         chipset_clk,
  input  logic         chipset_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst || clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/polara_noc_rx_checker.sv
// Per-channel NoC receive checker: parses header/payload, counts packets/flits, flags header
// mismatches and mid-packet idle timeouts.
//   state     | meaning
//   S_HDR     | next accepted flit is a header
//   S_PAYLOAD | collecting 'remaining' payload flits; idle timer running while en=1
module polara_noc_rx_checker
  import polara_noc_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int          CNT_W       = 32,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [13:0] EXP_CHIPID  = 14'h2000
) (
  input  logic              chipset_clk,
  input  logic              chipset_rst,
  input  logic              en,
  input  logic              clr,
  input  logic [7:0]        exp_msg_type,
  input  logic [DATA_W-1:0] data_i,
  input  logic              val_i,
  output logic              rdy_o,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_hdr,
  output logic              timeout,
  output logic [DATA_W-1:0] last_hdr,
  output logic              busy
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  rx_state_e          state;
  logic [LEN_W-1:0]   remaining;
  logic [TMR_W-1:0]   timer;

  logic               accept;
  logic               hdr_acc;
  logic               pay_acc;
  logic [LEN_W-1:0]   hdr_len;
  logic               mismatch;
  logic               pkt_done;
  logic               to_evt;

  assign rdy_o    = en;
  assign accept   = val_i & en;
  assign hdr_acc  = accept & (state == S_HDR);
  assign pay_acc  = accept & (state == S_PAYLOAD);
  assign hdr_len  = data_i[LEN_LSB +: LEN_W];
  assign mismatch = hdr_acc & ((data_i[CHIPID_LSB +: CHIPID_W] != EXP_CHIPID) ||
                               (data_i[MSG_LSB +: MSG_W] != exp_msg_type));
  assign pkt_done = (hdr_acc & (hdr_len == '0)) | (pay_acc & (remaining == LEN_W'(1)));
  assign to_evt   = (state == S_PAYLOAD) & en & ~val_i & (timer == TMR_LAST);
  assign busy     = (state == S_PAYLOAD);

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      state     <= S_HDR;
      remaining <= '0;
      timer     <= '0;
      err_hdr   <= 1'b0;
      timeout   <= 1'b0;
      last_hdr  <= '0;
    end else begin
      case (state)
        S_HDR: begin
          if (hdr_acc) begin
            last_hdr <= data_i;
            if (hdr_len != '0) begin
              remaining <= hdr_len;
              timer     <= '0;
              state     <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (pay_acc) begin
            remaining <= remaining - 1'b1;
            timer     <= '0;
            if (remaining == LEN_W'(1)) state <= S_HDR;
          end else if (en) begin
            if (timer == TMR_LAST) begin
              timer <= '0;
              state <= S_HDR;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: state <= S_HDR;
      endcase

      // Sticky flags follow the counters: clear wins over a same-cycle event.
      if (clr) begin
        err_hdr <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (mismatch) err_hdr <= 1'b1;
        if (to_evt)   timeout <= 1'b1;
      end
    end
  end

  polara_sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .chipset_clk (chipset_clk),
    .chipset_rst (chipset_rst),
    .clr         (clr),
    .inc         (pkt_done),
    .cnt         (pkt_cnt)
  );

  polara_sat_counter #(.W(CNT_W)) u_flit_cnt (
    .chipset_clk (chipset_clk),
    .chipset_rst (chipset_rst),
    .clr         (clr),
    .inc         (accept),
    .cnt         (flit_cnt)
  );

  polara_sat_counter #(.W(CNT_W)) u_err_cnt (
    .chipset_clk (chipset_clk),
    .chipset_rst (chipset_rst),
    .clr         (clr),
    .inc         (mismatch),
    .cnt         (err_cnt)
  );

endmodule

// File: tb/tb_polara_noc_rx_checker.sv
// Self-checking bench for polara_noc_rx_checker: table-driven header/payload vectors with a
// scoreboard queue, plus directed clear, timeout, enable-freeze, reset and saturation sequences.
module tb_polara_noc_rx_checker;
  import polara_noc_pkg::*;

  localparam int DATA_W      = 64;
  localparam int CNT_W       = 6;
  localparam int TIMEOUT_CYC = 1024;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              chipset_clk = 1'b0;
  logic              chipset_rst;
  logic              en;
  logic              clr;
  logic [7:0]        exp_msg_type;
  logic [DATA_W-1:0] data_i;
  logic              val_i;
  logic              rdy_o;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  flit_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_hdr;
  logic              timeout;
  logic [DATA_W-1:0] last_hdr;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles = 0;

  polara_noc_rx_checker #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .EXP_CHIPID  (14'h2000)
  ) dut (
    .chipset_clk  (chipset_clk),
    .chipset_rst  (chipset_rst),
    .en           (en),
    .clr          (clr),
    .exp_msg_type (exp_msg_type),
    .data_i       (data_i),
    .val_i        (val_i),
    .rdy_o        (rdy_o),
    .pkt_cnt      (pkt_cnt),
    .flit_cnt     (flit_cnt),
    .err_cnt      (err_cnt),
    .err_hdr      (err_hdr),
    .timeout      (timeout),
    .last_hdr     (last_hdr),
    .busy         (busy)
  );

  always #5 chipset_clk = ~chipset_clk;

  always @(negedge chipset_clk) if (busy === 1'b1) busy_cycles++;

  typedef struct {
    logic [63:0] flit;
    int          exp_pkt;
    int          exp_flit;
    int          exp_err;
    bit          exp_errh;
    bit          exp_busy;
    logic [63:0] exp_last;
  } vec_t;

  vec_t vecs [9];
  vec_t sb_q [$];

  function automatic logic [63:0] hdr(input logic [13:0] chip, input logic [7:0] len,
                                      input logic [7:0] msg);
    return {chip, 8'h03, 8'h04, 4'h0, len, msg, 8'h12, 6'h00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_flit(input logic [63:0] d);
    val_i  = 1'b1;
    data_i = d;
    @(posedge chipset_clk);
    #1;
    val_i  = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int p, input int f, input int e);
    check({tag, ".pkt_cnt"},  64'(pkt_cnt),  64'(p));
    check({tag, ".flit_cnt"}, 64'(flit_cnt), 64'(f));
    check({tag, ".err_cnt"},  64'(err_cnt),  64'(e));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge chipset_clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] h_ok0, h_len3, h_bad_chip, h_bad_msg, h;
    vec_t v;

    h_ok0      = hdr(14'h2000, 8'd0, MSG_TYPE_INV_FWD);
    h_len3     = hdr(14'h2000, 8'd3, MSG_TYPE_INV_FWD);
    h_bad_chip = hdr(14'h0001, 8'd0, MSG_TYPE_INV_FWD);
    h_bad_msg  = hdr(14'h2000, 8'd1, MSG_TYPE_LOAD_FWD);

    //              flit                 pkt flit err errh busy last_hdr
    vecs[0] = '{h_ok0,                1, 1, 0, 1'b0, 1'b0, h_ok0};
    vecs[1] = '{h_len3,               1, 2, 0, 1'b0, 1'b1, h_len3};
    vecs[2] = '{64'hA5A5_0000_0000_0001, 1, 3, 0, 1'b0, 1'b1, h_len3};
    vecs[3] = '{64'hA5A5_0000_0000_0002, 1, 4, 0, 1'b0, 1'b1, h_len3};
    vecs[4] = '{64'hA5A5_0000_0000_0003, 2, 5, 0, 1'b0, 1'b0, h_len3};
    vecs[5] = '{h_ok0,                3, 6, 0, 1'b0, 1'b0, h_ok0};
    vecs[6] = '{h_bad_chip,           4, 7, 1, 1'b1, 1'b0, h_bad_chip};
    vecs[7] = '{h_bad_msg,            4, 8, 2, 1'b1, 1'b1, h_bad_msg};
    vecs[8] = '{64'h5A5A_FFFF_0000_0009, 5, 9, 2, 1'b1, 1'b0, h_bad_msg};

    chipset_rst  = 1'b1;
    en           = 1'b0;
    clr          = 1'b0;
    val_i        = 1'b0;
    data_i       = '0;
    exp_msg_type = MSG_TYPE_INV_FWD;
    repeat (3) @(posedge chipset_clk);
    #1;
    check("reset.rdy_o", 64'(rdy_o), 64'(0));
    check_counts("reset", 0, 0, 0);
    check("reset.err_hdr", 64'(err_hdr), 64'(0));
    check("reset.timeout", 64'(timeout), 64'(0));
    check("reset.last_hdr", last_hdr, 64'(0));
    check("reset.busy", 64'(busy), 64'(0));
    chipset_rst = 1'b0;
    en          = 1'b1;
    #1;
    check("en.rdy_o", 64'(rdy_o), 64'(1));

    // Table vectors, back-to-back with val_i held high
    busy_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back(vecs[i]);
      drive_flit(vecs[i].flit);
      v = sb_q.pop_front();
      check_counts($sformatf("vec%0d", i), v.exp_pkt, v.exp_flit, v.exp_err);
      check($sformatf("vec%0d.err_hdr", i), 64'(err_hdr), 64'(v.exp_errh));
      check($sformatf("vec%0d.busy", i), 64'(busy), 64'(v.exp_busy));
      check($sformatf("vec%0d.last_hdr", i), last_hdr, v.exp_last);
      if (i == 5) check("len3.busy_cycles", 64'(busy_cycles), 64'(3));
    end

    pulse_clr();
    check_counts("clr", 0, 0, 0);
    check("clr.err_hdr", 64'(err_hdr), 64'(0));

    // clr coincident with a mismatching header accept: clr wins, last_hdr still updates
    clr = 1'b1;
    drive_flit(h_bad_chip | 64'h40);
    clr = 1'b0;
    check_counts("clr_acc", 0, 0, 0);
    check("clr_acc.err_hdr", 64'(err_hdr), 64'(0));
    check("clr_acc.last_hdr", last_hdr, h_bad_chip | 64'h40);

    // Payload timeout
    h = hdr(14'h2000, 8'd2, MSG_TYPE_INV_FWD);
    drive_flit(h);
    drive_flit(64'h1111);
    repeat (TIMEOUT_CYC - 1) @(posedge chipset_clk);
    #1;
    check("to_edge.timeout", 64'(timeout), 64'(0));
    check("to_edge.busy", 64'(busy), 64'(1));
    @(posedge chipset_clk);
    #1;
    check("to.timeout", 64'(timeout), 64'(1));
    check("to.busy", 64'(busy), 64'(0));
    check_counts("to", 0, 2, 0);
    drive_flit(h_ok0);
    check_counts("to_next", 1, 3, 0);
    check("to_next.last_hdr", last_hdr, h_ok0);
    pulse_clr();
    check("to_clr.timeout", 64'(timeout), 64'(0));

    // en=0 freeze mid-packet
    drive_flit(h);
    drive_flit(64'h2222);
    en     = 1'b0;
    val_i  = 1'b1;
    data_i = 64'h3333;
    repeat (5000) @(posedge chipset_clk);
    #1;
    check("en0.rdy_o", 64'(rdy_o), 64'(0));
    check("en0.timeout", 64'(timeout), 64'(0));
    check("en0.busy", 64'(busy), 64'(1));
    check_counts("en0", 0, 2, 0);
    en = 1'b1;
    drive_flit(64'h4444);
    check_counts("en1", 1, 3, 0);
    check("en1.busy", 64'(busy), 64'(0));

    // Reset mid-packet
    pulse_clr();
    drive_flit(hdr(14'h2000, 8'd4, MSG_TYPE_INV_FWD));
    drive_flit(64'h5555);
    chipset_rst = 1'b1;
    @(posedge chipset_clk);
    #1;
    chipset_rst = 1'b0;
    check_counts("rst_mid", 0, 0, 0);
    check("rst_mid.busy", 64'(busy), 64'(0));
    check("rst_mid.last_hdr", last_hdr, 64'(0));
    drive_flit(h_ok0);
    check_counts("rst_next", 1, 1, 0);

    // Saturation
    pulse_clr();
    for (int i = 0; i < CNT_MAX + 7; i++) drive_flit(h_ok0);
    check_counts("sat", CNT_MAX, CNT_MAX, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
